// File: rtl/inst_queue_pkg.sv
// Shared types and widths for the IF->ID instruction queue.
// ExcE_W is the width of the IF exception vector. IQ_ENTRY_W is the width of
// one stored entry, and the *_LSB values give each field's position in it.
package inst_queue_pkg;

  localparam int unsigned ExcE_W     = 8;
  localparam int unsigned IQ_ENTRY_W = 32 + 32 + 1 + ExcE_W + 1;

  // Field offsets inside a packed entry (has_exc in the LSB, pc in the MSBs)
  localparam int unsigned IQ_HAS_EXC_LSB = 0;
  localparam int unsigned IQ_EXCS_LSB    = IQ_HAS_EXC_LSB + 1;
  localparam int unsigned IQ_INSLOT_LSB  = IQ_EXCS_LSB + ExcE_W;
  localparam int unsigned IQ_INST_LSB    = IQ_INSLOT_LSB + 1;
  localparam int unsigned IQ_PC_LSB      = IQ_INST_LSB + 32;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              inslot;
    logic [ExcE_W-1:0] excs;
    logic              has_exc;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_ram.sv
// Storage for inst_queue.
// It is a DEPTH x W register array with one write port and one
// asynchronous read port. All entries clear on reset.
module iq_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Register array: cleared on reset, one entry written per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between IF and ID. It buffers fetched
// {pc, inst, inslot, excs, has_exc} entries in FIFO order.
// Optional macro INST_QUEUE_BYPASS_EN: when the queue is empty, the IF
// entry is forwarded to ID combinationally. If ID also consumes it in that
// cycle, the entry is never written to storage.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              if_valid_i,
  input  logic [31:0]       if_pc_i,
  input  logic [31:0]       if_inst_i,
  input  logic              if_inslot_i,
  input  logic [ExcE_W-1:0] if_excs_i,
  input  logic              if_has_exc_i,
  output logic              if_ready_o,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [31:0]       id_pc_o,
  output logic [31:0]       id_inst_o,
  output logic              id_inslot_o,
  output logic [ExcE_W-1:0] id_excs_o,
  output logic              id_has_exc_o,
  output logic [PTR_W:0]    iq_count_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  iq_entry_t        wr_entry, rd_entry, out_entry;
  logic             empty, push, pop, wr_en, rd_en;

  assign empty      = (count == '0);
  assign if_ready_o = (count != FULL_CNT);
  assign push       = if_valid_i & if_ready_o & ~flush_i;
  assign pop        = id_valid_o & id_ready_i;
  assign iq_count_o = count;

  assign wr_entry = '{pc: if_pc_i, inst: if_inst_i, inslot: if_inslot_i,
                      excs: if_excs_i, has_exc: if_has_exc_i};

`ifdef INST_QUEUE_BYPASS_EN
  logic bypass;
  // When the queue is empty, the head is the IF entry itself.
  // A pop in that case does not touch storage.
  assign bypass     = empty & ~flush_i;
  assign id_valid_o = bypass ? if_valid_i : (~empty & ~flush_i);
  assign out_entry  = bypass ? wr_entry : rd_entry;
  assign wr_en      = push & ~(bypass & id_ready_i);
  assign rd_en      = pop & ~empty;
`else
  assign id_valid_o = ~empty & ~flush_i;
  assign out_entry  = rd_entry;
  assign wr_en      = push;
  assign rd_en      = pop;
`endif

  assign id_pc_o      = out_entry.pc;
  assign id_inst_o    = out_entry.inst;
  assign id_inslot_o  = out_entry.inslot;
  assign id_excs_o    = out_entry.excs;
  assign id_has_exc_o = out_entry.has_exc;

  // Pointer and occupancy tracking; flush rewinds both pointers, storage is left as is
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  iq_ram #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W),
    .W    (IQ_ENTRY_W)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(wr_entry),
    .rd_addr(rd_ptr),
    .rd_data(rd_entry)
  );

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue.
// Accepted pushes are queued as expected entries. The monitor compares every
// ID handshake against the head of that queue.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n, flush_i, if_valid_i, if_inslot_i, if_has_exc_i;
  logic [31:0]       if_pc_i, if_inst_i;
  logic [ExcE_W-1:0] if_excs_i;
  logic              if_ready_o, id_valid_o, id_ready_i;
  logic [31:0]       id_pc_o, id_inst_o;
  logic              id_inslot_o, id_has_exc_o;
  logic [ExcE_W-1:0] id_excs_o;
  logic [PTR_W:0]    iq_count_o;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
    .if_inslot_i(if_inslot_i), .if_excs_i(if_excs_i), .if_has_exc_i(if_has_exc_i),
    .if_ready_o(if_ready_o), .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_inslot_o(id_inslot_o),
    .id_excs_o(id_excs_o), .id_has_exc_o(id_has_exc_o), .iq_count_o(iq_count_o)
  );

  iq_entry_t exp_q[$];
  iq_entry_t mon_e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ID handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n === 1'b1 && id_valid_o === 1'b1 && id_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h expected no entry", id_pc_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", id_pc_o, mon_e.pc);
        chk("pop_inst", id_inst_o, mon_e.inst);
        chk("pop_inslot", 32'(id_inslot_o), 32'(mon_e.inslot));
        chk("pop_excs", 32'(id_excs_o), 32'(mon_e.excs));
        chk("pop_has_exc", 32'(id_has_exc_o), 32'(mon_e.has_exc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one IF entry; record it as expected when the bench knows it is accepted
  task automatic set_if(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic slot, input logic [ExcE_W-1:0] excs, input logic hx,
                        input bit expect_it);
    iq_entry_t e;
    if_valid_i   = v;
    if_pc_i      = pc;
    if_inst_i    = inst;
    if_inslot_i  = slot;
    if_excs_i    = excs;
    if_has_exc_i = hx;
    if (expect_it) begin
      e = '{pc: pc, inst: inst, inslot: slot, excs: excs, has_exc: hx};
      exp_q.push_back(e);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
    set_if(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_count", 32'(iq_count_o), 32'd0);
    chk("rst_ready", 32'(if_ready_o), 32'd1);
    chk("rst_inst", id_inst_o, 32'd0);
    chk("rst_pc", id_pc_o, 32'd0);

    // Reset mid-stream with 3 entries queued
    tick();
    for (int i = 0; i < 3; i++) begin
      set_if(1'b1, 32'hbfc00100 + 32'(4*i), 32'ha1 + 32'(i), 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    if_valid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 32'(iq_count_o), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(id_valid_o), 32'd0);
    chk("mid_rst_count", 32'(iq_count_o), 32'd0);
    chk("mid_rst_ready", 32'(if_ready_o), 32'd1);
    chk("mid_rst_inst", id_inst_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fill to full, try a 5th push, then drain in order
    for (int i = 0; i < 4; i++) begin
      set_if(1'b1, 32'hbfc00000 + 32'(4*i), 32'h11 + 32'(i), 1'(i % 2), ExcE_W'(i), 1'b0, 1'b1);
      tick();
    end
    set_if(1'b1, 32'hbfc00010, 32'h15, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", 32'(iq_count_o), 32'd4);
    chk("full_ready", 32'(if_ready_o), 32'd0);
    tick();
    if_valid_i = 1'b0;
    @(negedge clk);
    chk("full_5th_ignored", 32'(iq_count_o), 32'd4);
    tick();
    id_ready_i = 1'b1;
    repeat (4) tick();
    id_ready_i = 1'b0;
    @(negedge clk);
    chk("drained_count", 32'(iq_count_o), 32'd0);
    tick();

    // Steady push+pop at count 2, wrapping the pointers
    for (int i = 0; i < 2; i++) begin
      set_if(1'b1, 32'hbfc00200 + 32'(4*i), 32'h200 + 32'(i), 1'b0, '0, 1'b0, 1'b1);
      tick();
    end
    id_ready_i = 1'b1;
    for (int i = 2; i < 12; i++) begin
      set_if(1'b1, 32'hbfc00200 + 32'(4*i), 32'h200 + 32'(i), 1'(i % 3 == 0), '0, 1'b0, 1'b1);
      @(negedge clk);
      chk("stream_count", 32'(iq_count_o), 32'd2);
      tick();
    end
    if_valid_i = 1'b0;
    @(negedge clk);
    chk("stream_end_count", 32'(iq_count_o), 32'd2);
    repeat (2) tick();
    id_ready_i = 1'b0;
    @(negedge clk);
    chk("stream_drained", 32'(iq_count_o), 32'd0);
    tick();

    // Flush with 3 queued and a concurrent push
    for (int i = 0; i < 3; i++) begin
      set_if(1'b1, 32'hbfc00300 + 32'(4*i), 32'h300 + 32'(i), 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
    set_if(1'b1, 32'hbfc00020, 32'h20, 1'b0, '0, 1'b0, 1'b0);
    flush_i = 1'b1;
    id_ready_i = 1'b1;
    @(negedge clk);
    chk("flush_valid", 32'(id_valid_o), 32'd0);
    chk("flush_pre_count", 32'(iq_count_o), 32'd3);
    tick();
    flush_i = 1'b0;
    if_valid_i = 1'b0;
    @(negedge clk);
    chk("post_flush_count", 32'(iq_count_o), 32'd0);
    chk("post_flush_valid", 32'(id_valid_o), 32'd0);
    repeat (3) tick();
    id_ready_i = 1'b0;

    // Exception and delay-slot flags are carried through unchanged
    set_if(1'b1, 32'hbfc00002, 32'h55, 1'b1, ExcE_W'(2), 1'b1, 1'b1);
    tick();
    if_valid_i = 1'b0;
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
    @(negedge clk);
    chk("exc_drained", 32'(iq_count_o), 32'd0);
    tick();

    // Latency from an empty queue with ID ready
    set_if(1'b1, 32'hbfc00030, 32'h66, 1'b0, '0, 1'b0, 1'b1);
    id_ready_i = 1'b1;
    @(negedge clk);
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_valid_same", 32'(id_valid_o), 32'd1);
    chk("byp_pc_same", id_pc_o, 32'hbfc00030);
`else
    chk("lat_valid_same", 32'(id_valid_o), 32'd0);
`endif
    tick();
    if_valid_i = 1'b0;
    @(negedge clk);
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_count_next", 32'(iq_count_o), 32'd0);
    chk("byp_valid_next", 32'(id_valid_o), 32'd0);
`else
    chk("lat_valid_next", 32'(id_valid_o), 32'd1);
    chk("lat_count_next", 32'(iq_count_o), 32'd1);
`endif
    tick();
    id_ready_i = 1'b0;
    repeat (2) tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
